// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch port, the load/store port and the memory macro signals shared by
// mem_port_arbiter and the blocks around it.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ready;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ready;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              stall;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_ready, if_rdata, d_ready, d_rdata, mem_en, mem_we, mem_addr, mem_wdata, stall
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_ready, if_rdata, d_ready, d_rdata, mem_en, mem_we, mem_addr, mem_wdata, stall
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between the fetch and load/store
// ports, with a fixed wait-state count and a one-cycle ready pulse per access.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input logic              clk,
    input logic              rst,
    mem_port_arbiter_if.slave bus
);
    localparam int unsigned CntW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              grant_q, grant_d;      // 1 = port D
    logic              last_q, last_d;        // 1 = port D was granted last
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              pick_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            grant_q    <= 1'b0;
            last_q     <= 1'b1;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        grant_d      = grant_q;
        last_d       = last_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        we_d         = we_q;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;
        pick_d       = 1'b0;
        bus.mem_en   = 1'b0;
        bus.mem_we   = 1'b0;
        bus.if_ready = 1'b0;
        bus.d_ready  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.if_req || bus.d_req) begin
                    // On a tie, D wins only if I was granted last
                    pick_d  = bus.d_req && (!bus.if_req || !last_q);
                    grant_d = pick_d;
                    last_d  = pick_d;
                    addr_d  = pick_d ? bus.d_addr : bus.if_addr;
                    wdata_d = pick_d ? bus.d_wdata : '0;
                    we_d    = pick_d && bus.d_we;
                    cnt_d   = CntW'(WAIT_CYCLES);
                    state_d = StAccess;
                end
            end
            StAccess: begin
                bus.mem_en = 1'b1;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CntW'(1);
                end else begin
                    bus.mem_we = we_q;
                    if (!we_q) begin
                        if (grant_q) d_rdata_d  = bus.mem_rdata;
                        else         if_rdata_d = bus.mem_rdata;
                    end
                    state_d = StResp;
                end
            end
            StResp: begin
                bus.if_ready = !grant_q;
                bus.d_ready  = grant_q;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.stall     = (bus.if_req && !bus.if_ready) || (bus.d_req && !bus.d_ready);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Drives mem_port_arbiter with directed and random fetch/load/store traffic and compares
// every cycle against a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned W  = 2;
    localparam int          WI = W;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    // Memory environment: data is only valid in the last access cycle
    logic [DW-1:0] env_mem [64];
    logic [DW-1:0] ref_mem [64];
    logic          rdata_valid = 1'b0;
    logic [DW-1:0] garbage     = '0;
    logic [DW-1:0] rd0         = '0;
    assign bus.mem_rdata  = rdata_valid ? env_mem[bus.mem_addr[7:2]] : garbage;
    assign bus0.mem_rdata = rd0;

    int total = 0;
    int bad   = 0;

    // Transaction model state
    int            cyc;
    bit            busy;
    int            g_c;
    bit            g_d;
    bit            last_d;
    logic [AW-1:0] l_addr;
    logic [DW-1:0] l_wdata;
    bit            l_we;
    logic [DW-1:0] exp_if_rdata, exp_d_rdata;
    bit            e_en, e_last, e_we, e_ifr, e_dr;
    int            dut_dr_cyc;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        busy         = 1'b0;
        last_d       = 1'b1;
        l_addr       = '0;
        l_wdata      = '0;
        l_we         = 1'b0;
        exp_if_rdata = '0;
        exp_d_rdata  = '0;
        e_ifr        = 1'b0;
        e_dr         = 1'b0;
    endfunction

    // Entered at posedge+1; leaves at the next posedge+1.
    task automatic tick();
        bit pick;
        e_en   = busy && cyc >= g_c + 1 && cyc <= g_c + WI + 1;
        e_last = busy && cyc == g_c + WI + 1;
        e_we   = e_last && l_we;
        e_ifr  = busy && cyc == g_c + WI + 2 && !g_d;
        e_dr   = busy && cyc == g_c + WI + 2 && g_d;
        rdata_valid = e_last && !l_we;
        garbage     = $urandom;
        if (e_last && l_we) ref_mem[l_addr[7:2]] = l_wdata;
        if (e_ifr && !l_we) exp_if_rdata = ref_mem[l_addr[7:2]];
        if (e_dr && !l_we)  exp_d_rdata  = ref_mem[l_addr[7:2]];
        @(negedge clk);
        check_eq("mem_en", bus.mem_en, e_en);
        check_eq("mem_we", bus.mem_we, e_we);
        check_eq("if_ready", bus.if_ready, e_ifr);
        check_eq("d_ready", bus.d_ready, e_dr);
        check_eq("stall", bus.stall, (bus.if_req && !e_ifr) || (bus.d_req && !e_dr));
        check_eq("if_rdata", bus.if_rdata, exp_if_rdata);
        check_eq("d_rdata", bus.d_rdata, exp_d_rdata);
        if (e_en) check_eq("mem_addr", bus.mem_addr, l_addr);
        if (e_en && l_we) check_eq("mem_wdata", bus.mem_wdata, l_wdata);
        if (bus.d_ready) dut_dr_cyc = cyc;
        if (bus.mem_en && bus.mem_we) env_mem[bus.mem_addr[7:2]] = bus.mem_wdata;
        if (!busy || cyc >= g_c + WI + 3) begin
            busy = 1'b0;
            if (bus.if_req || bus.d_req) begin
                pick    = bus.d_req && (!bus.if_req || !last_d);
                busy    = 1'b1;
                g_c     = cyc;
                g_d     = pick;
                last_d  = pick;
                l_addr  = pick ? bus.d_addr : bus.if_addr;
                l_we    = pick && bus.d_we;
                l_wdata = bus.d_wdata;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n, input bit renew_i, input bit renew_d);
        for (int k = 0; k < n; k++) begin
            tick();
            if (e_ifr) bus.if_req = renew_i;
            if (e_dr)  bus.d_req  = renew_d;
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 60 && (bus.if_req || bus.d_req); k++) begin
            tick();
            if (e_ifr) bus.if_req = 1'b0;
            if (e_dr)  bus.d_req  = 1'b0;
        end
        check_eq("drain_timeout", {bus.if_req, bus.d_req}, 2'b00);
        tick();
    endtask

    function automatic logic [AW-1:0] rand_addr();
        logic [AW-1:0] a;
        a = (AW'($urandom_range(0, 3)) << 12) | (AW'($urandom) & 32'hFC);
        return a;
    endfunction

    task automatic drive_random();
        if (bus.if_req ? e_ifr : ($urandom_range(0, 2) == 0)) begin
            bus.if_req  = (bus.if_req ? $urandom_range(0, 1) : 1) != 0;
            bus.if_addr = rand_addr();
        end
        if (bus.d_req ? e_dr : ($urandom_range(0, 2) == 0)) begin
            bus.d_req   = (bus.d_req ? $urandom_range(0, 1) : 1) != 0;
            bus.d_we    = $urandom_range(0, 1) != 0;
            bus.d_addr  = rand_addr();
            bus.d_wdata = $urandom;
        end
    endtask

    initial begin
        logic [DW-1:0] v;
        int            t1;
        bus.if_req = 0; bus.if_addr = '0; bus.d_req = 0; bus.d_we = 0;
        bus.d_addr = '0; bus.d_wdata = '0;
        bus0.if_req = 0; bus0.if_addr = '0; bus0.d_req = 0; bus0.d_we = 0;
        bus0.d_addr = '0; bus0.d_wdata = '0;
        for (int i = 0; i < 64; i++) begin
            v = $urandom;
            env_mem[i] = v;
            ref_mem[i] = v;
        end
        model_reset();
        cyc = 0;
        dut_dr_cyc = -1;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_mem_en", bus.mem_en, 0);
        check_eq("rst_mem_we", bus.mem_we, 0);
        check_eq("rst_ready", {bus.if_ready, bus.d_ready}, 0);
        check_eq("rst_mem_addr", bus.mem_addr, 0);
        check_eq("rst_mem_wdata", bus.mem_wdata, 0);
        check_eq("rst_rdata", {bus.if_rdata, bus.d_rdata}, 0);
        check_eq("rst0_mem_en", bus0.mem_en, 0);
        rst = 1'b1;

        // WAIT_CYCLES=0 build: single fetch
        bus0.if_req = 1; bus0.if_addr = 32'h10; rd0 = 32'h00500093;
        #1 check_eq("w0_c0_stall", bus0.stall, 1);
        check_eq("w0_c0_en", bus0.mem_en, 0);
        @(posedge clk); #1;
        check_eq("w0_c1_en", bus0.mem_en, 1);
        check_eq("w0_c1_addr", bus0.mem_addr, 32'h10);
        check_eq("w0_c1_ready", bus0.if_ready, 0);
        @(posedge clk); #1;
        check_eq("w0_c2_ready", bus0.if_ready, 1);
        check_eq("w0_c2_rdata", bus0.if_rdata, 32'h00500093);
        check_eq("w0_c2_en", bus0.mem_en, 0);
        check_eq("w0_c2_stall", bus0.stall, 0);
        bus0.if_req = 0;
        @(posedge clk); #1;
        check_eq("w0_c3_ready", bus0.if_ready, 0);

        // Single fetch
        env_mem[4] = 32'h00500093; ref_mem[4] = 32'h00500093;
        bus.if_req = 1; bus.if_addr = 32'h10;
        drain();
        check_eq("t1_if_rdata", bus.if_rdata, 32'h00500093);

        // Store
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h100; bus.d_wdata = 32'hDEADBEEF;
        drain();
        check_eq("t2_mem", env_mem[0], 32'hDEADBEEF);
        check_eq("t2_d_rdata", bus.d_rdata, 0);

        // Simultaneous requests: I, D, I
        bus.if_req = 1; bus.if_addr = 32'h20;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h104;
        run(3 * (WI + 3), 1'b1, 1'b1);
        drain();

        // Two loads on D alone
        env_mem[0] = 32'h11111111; ref_mem[0] = 32'h11111111;
        env_mem[1] = 32'h22222222; ref_mem[1] = 32'h22222222;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h200;
        dut_dr_cyc = -1;
        for (int k = 0; k < 20 && !e_dr; k++) tick();
        t1 = dut_dr_cyc;
        check_eq("t4_rd1", bus.d_rdata, 32'h11111111);
        bus.d_addr = 32'h204;
        drain();
        check_eq("t4_rd2", bus.d_rdata, 32'h22222222);
        check_eq("t4_gap", dut_dr_cyc - t1, WI + 3);

        // Reset in the second access cycle of a load
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h208;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check_eq("t5_mem_en", bus.mem_en, 0);
        check_eq("t5_mem_we", bus.mem_we, 0);
        check_eq("t5_d_ready", bus.d_ready, 0);
        check_eq("t5_d_rdata", bus.d_rdata, 0);
        check_eq("t5_if_rdata", bus.if_rdata, 0);
        rdata_valid = 1'b0;
        @(posedge clk); #1;
        check_eq("t5_hold_d_ready", bus.d_ready, 0);
        rst = 1'b1;
        model_reset();
        drain();

        // Random traffic
        for (int k = 0; k < 2000; k++) begin
            tick();
            drive_random();
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port memory between the core's instruction-fetch port (port I) and data load/store port (port D).
- Intended for a unified-memory build of the single-cycle core, where IMEM and DMEM are backed by one slow array.
- Sequences each access through a fixed wait-state count, returns the response with a one-cycle ready pulse, and raises a stall so the core holds PC and register write-back.
- Sits between the core's fetch/load-store paths and the memory macro.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.
- WAIT_CYCLES, 2, extra memory cycles per access (0 allowed); counter width is clog2(WAIT_CYCLES+1), minimum 1 bit.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held until if_ready.
- if_addr  in  ADDR_W  fetch address (PC).
- if_ready  out  1  one-cycle pulse: if_rdata valid, request done.
- if_rdata  out  DATA_W  fetched instruction (registered).
- d_req  in  1  data request; held until d_ready.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address (ALU result).
- d_wdata  in  DATA_W  store data.
- d_ready  out  1  one-cycle completion pulse for port D.
- d_rdata  out  DATA_W  load data (registered).
- mem_en  out  1  memory enable.
- mem_we  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid in the last ACCESS cycle.
- stall  out  1  (if_req & ~if_ready) | (d_req & ~d_ready), combinational.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE; counter = 0; last_grant = D, so port I wins the first tie.
  - mem_en, mem_we, if_ready and d_ready = 0.
  - mem_addr, mem_wdata, if_rdata and d_rdata = 0.
- States are IDLE, ACCESS and RESP.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one request pending: grant it.
  - Both pending: grant the port that is not last_grant (round-robin).
  - On grant, at the clock edge: latch grant, addr, wdata and we (we is forced 0 for port I); load counter = WAIT_CYCLES; update last_grant; go to ACCESS.
- ACCESS:
  - mem_en = 1 with the latched address and data, stable for the whole state.
  - Counter != 0: decrement and stay.
  - Counter == 0: mem_we = latched we for this cycle only. At the edge, a granted load/fetch captures mem_rdata into that port's rdata register; go to RESP.
  - ACCESS lasts WAIT_CYCLES+1 cycles.
- RESP:
  - ready = 1 for the granted port only, for exactly one cycle; mem_en = 0.
  - Next state is always IDLE.
- Latency: request seen in IDLE cycle 0 gives ready in cycle WAIT_CYCLES+2. Back-to-back issue interval is WAIT_CYCLES+3 cycles.
- rdata registers hold their value until the next read completes on the same port. A store never changes d_rdata.
- The non-granted port is unaffected: its request stays pending and is granted in the next IDLE.
- A request dropped mid-access is a protocol violation. The access still completes, including the write, and the ready pulse is still issued.
- Request inputs sampled in ACCESS or RESP are ignored until IDLE.
- Reset mid-ACCESS: mem_en and mem_we drop immediately, no ready is issued, and no rdata is updated.
- stall is purely combinational, with no reset dependence beyond the ready outputs.

Test Plan:
- Reset then single fetch: rst low 3 cycles, then if_req=1, if_addr=0x00000010, mem_rdata=0x00500093 → mem_en high for 3 cycles with mem_addr=0x10, if_ready pulses in cycle 4, if_rdata=0x00500093, stall=1 for cycles 0–3.
- Store: d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF → mem_we high only in the 3rd ACCESS cycle with mem_wdata=0xDEADBEEF, d_ready pulses in cycle 4, d_rdata unchanged.
- Simultaneous requests after reset: if_req=d_req=1 → I granted first (if_ready in cycle 4). D granted in the next IDLE (cycle 5), d_ready in cycle 9. Repeating with both held alternates I, D, I.
- Single-port repetition: only d_req held for two loads (0x200→0x11111111, 0x204→0x22222222) → d_rdata=0x11111111 then 0x22222222, d_ready pulses 5 cycles apart.
- Reset mid-access: assert rst in the 2nd ACCESS cycle of a load → mem_en=0 the same cycle, d_ready never pulses, d_rdata=0. After release with d_req still high, the access restarts from IDLE.
- WAIT_CYCLES=0 build: single fetch → ACCESS is 1 cycle and if_ready is in cycle 2.
